// File: rtl/ir_command_ctrl_if.sv
// Command byte stream leaving the IR controller: valid/ready handshake.
// The controller drives the master side, the command consumer the slave side.
interface ir_command_ctrl_if;
    logic [7:0] cmd_out;
    logic       cmd_valid_out;
    logic       cmd_ready_in;

    modport master (output cmd_out, output cmd_valid_out, input cmd_ready_in);
    modport slave  (input cmd_out, input cmd_valid_out, output cmd_ready_in);
endinterface

// File: rtl/ir_command_ctrl.sv
// IR remote command controller: supervises the frame decoder, validates frames,
// suppresses key repeats and queues accepted commands in a 4-deep FIFO.
module ir_command_ctrl #(
    parameter logic [7:0]  DEV_ADDR   = 8'h00,
    parameter int unsigned HOLDOFF    = 11_000_000,
    parameter int unsigned TIMEOUT    = 12_000_000,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              enable_in,
    input  logic [31:0]       code_in,
    input  logic              new_code_in,
    input  logic [3:0]        dec_state_in,
    output logic              dec_rst_out,
    ir_command_ctrl_if.master cmd_if,
    output logic [7:0]        drop_count_out,
    output logic [1:0]        state_out
);

    localparam int HOLD_W = $clog2(HOLDOFF + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int RC_W   = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        START   = 2'd1,
        RUN     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state;
    logic [RC_W-1:0]   phase_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [HOLD_W-1:0] holdoff_cnt;
    logic [7:0]        last_cmd;
    logic [7:0]        fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_cnt;
    logic [7:0]        cmd_reg;
    logic              cmd_valid_reg;
    logic [7:0]        drop_cnt;

    // Assertion is immediate; release is retimed through two flops.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [7:0] f_a, f_na, f_c, f_nc;
    logic       frame_seen, integ_ok, frame_valid, repeat_hit, accept;
    logic       pop, push_ok, drop_evt;
    logic [1:0] rd_next;
    logic [2:0] cnt_next;
    logic [7:0] head_next;

    assign {f_a, f_na, f_c, f_nc} = code_in;
    assign frame_seen  = new_code_in && enable_in && (state == RUN);
    assign integ_ok    = (f_na == ~f_a) && (f_nc == ~f_c);
    assign frame_valid = frame_seen && integ_ok && (f_a == DEV_ADDR);
    assign repeat_hit  = (f_c == last_cmd) && (holdoff_cnt != '0);
    assign accept      = frame_valid && !repeat_hit;
    assign pop         = cmd_valid_reg && cmd_if.cmd_ready_in;
    assign push_ok     = accept && ((fifo_cnt != 3'd4) || pop);
    assign drop_evt    = (frame_seen && !integ_ok) || (accept && !push_ok);
    assign rd_next     = rd_ptr + {1'b0, pop};
    assign cnt_next    = fifo_cnt + {2'b00, push_ok} - {2'b00, pop};
    // A push into a queue that is (or is becoming) empty lands straight at the head.
    assign head_next   = (push_ok && (fifo_cnt == {2'b00, pop})) ? f_c : fifo_mem[rd_next];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            phase_cnt   <= '0;
            to_cnt      <= '0;
            dec_rst_out <= 1'b1;
        end else if (!enable_in) begin
            state       <= OFF;
            phase_cnt   <= '0;
            to_cnt      <= '0;
            dec_rst_out <= 1'b1;
        end else begin
            case (state)
                OFF: begin
                    state       <= START;
                    phase_cnt   <= '0;
                    dec_rst_out <= 1'b1;
                end
                START, RECOVER: begin
                    if (phase_cnt == RC_LAST) begin
                        state       <= RUN;
                        phase_cnt   <= '0;
                        dec_rst_out <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + RC_W'(1);
                    end
                end
                RUN: begin
                    if (dec_state_in == 4'd0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= RECOVER;
                        to_cnt      <= '0;
                        dec_rst_out <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state       <= OFF;
                    dec_rst_out <= 1'b1;
                end
            endcase
        end
    end

    // Disabling flushes the queue and forgets repeat history but keeps cmd_out and drops.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            cmd_reg       <= '0;
            cmd_valid_reg <= 1'b0;
            holdoff_cnt   <= '0;
            last_cmd      <= '0;
            drop_cnt      <= '0;
        end else if (!enable_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            cmd_valid_reg <= 1'b0;
            holdoff_cnt   <= '0;
            last_cmd      <= '0;
        end else begin
            if (frame_valid) begin
                holdoff_cnt <= HOLD_LOAD;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - HOLD_W'(1);
            end
            if (accept) begin
                last_cmd <= f_c;
            end
            if (push_ok) begin
                fifo_mem[wr_ptr] <= f_c;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            rd_ptr        <= rd_next;
            fifo_cnt      <= cnt_next;
            cmd_valid_reg <= (cnt_next != 3'd0);
            if (cnt_next != 3'd0) begin
                cmd_reg <= head_next;
            end
            if (drop_evt && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign cmd_if.cmd_out       = cmd_reg;
    assign cmd_if.cmd_valid_out = cmd_valid_reg;
    assign drop_count_out       = drop_cnt;
    assign state_out            = state;

endmodule

// File: tb/tb_ir_command_ctrl.sv
// Bench for ir_command_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_ir_command_ctrl;

    localparam int         HOLDOFF_T = 1200;
    localparam int         TIMEOUT_T = 200;
    localparam int         RST_T     = 4;
    localparam logic [7:0] DEV       = 8'h00;

    localparam int M_OFF = 0, M_START = 1, M_RUN = 2, M_RECOVER = 3;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        enable_in;
    logic [31:0] code_in;
    logic        new_code_in;
    logic [3:0]  dec_state_in;
    logic        dec_rst_out;
    logic [7:0]  drop_count_out;
    logic [1:0]  state_out;

    ir_command_ctrl_if cmd_bus ();

    ir_command_ctrl #(
        .DEV_ADDR  (DEV),
        .HOLDOFF   (HOLDOFF_T),
        .TIMEOUT   (TIMEOUT_T),
        .RST_CYCLES(RST_T)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .enable_in     (enable_in),
        .code_in       (code_in),
        .new_code_in   (new_code_in),
        .dec_state_in  (dec_state_in),
        .dec_rst_out   (dec_rst_out),
        .cmd_if        (cmd_bus.master),
        .drop_count_out(drop_count_out),
        .state_out     (state_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: controller phase as plain integers, FIFO as a queue.
    int m_state, m_phase, m_hang, m_holdoff, m_sync, m_drop, m_last, m_cmd_out;
    int m_q[$];
    int drained[$];

    typedef struct {
        logic [31:0] code;
        logic        strobe;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_cmd;
        int          exp_drop;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_state   = M_OFF;
        m_phase   = 0;
        m_hang    = 0;
        m_holdoff = 0;
        m_sync    = 0;
        m_drop    = 0;
        m_last    = 0;
        m_cmd_out = 0;
        m_q.delete();
    endtask

    task automatic bumpDrop();
        if (m_drop < 255) m_drop++;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic modelStep();
        logic [7:0] a, na, c, nc;
        bit popped, want_push;
        int hold_before;
        if (!rst_n_in) begin
            modelReset();
        end else if (m_sync < 2) begin
            m_sync++;
        end else begin
            popped    = (m_q.size() != 0) && cmd_bus.cmd_ready_in;
            want_push = 1'b0;
            {a, na, c, nc} = code_in;
            if (!enable_in) begin
                m_state   = M_OFF;
                m_phase   = 0;
                m_hang    = 0;
                m_holdoff = 0;
                m_last    = 0;
                m_q.delete();
            end else begin
                hold_before = m_holdoff;
                if (m_holdoff > 0) m_holdoff--;
                if (m_state == M_RUN && new_code_in) begin
                    if (na != ~a || nc != ~c) begin
                        bumpDrop();
                    end else if (a == DEV) begin
                        m_holdoff = HOLDOFF_T;
                        if (!(int'(c) == m_last && hold_before != 0)) begin
                            m_last    = int'(c);
                            want_push = 1'b1;
                        end
                    end
                end
                if (popped) void'(m_q.pop_front());
                if (want_push) begin
                    if (m_q.size() < 4) m_q.push_back(int'(c));
                    else bumpDrop();
                end
                case (m_state)
                    M_OFF: begin
                        m_state = M_START;
                        m_phase = 0;
                    end
                    M_START, M_RECOVER: begin
                        m_phase++;
                        if (m_phase == RST_T) begin
                            m_state = M_RUN;
                            m_phase = 0;
                        end
                    end
                    default: begin
                        if (dec_state_in == 4'd0) begin
                            m_hang = 0;
                        end else begin
                            m_hang++;
                            if (m_hang == TIMEOUT_T) begin
                                m_state = M_RECOVER;
                                m_hang  = 0;
                                m_phase = 0;
                            end
                        end
                    end
                endcase
            end
            if (m_q.size() != 0) m_cmd_out = m_q[0];
        end
    endtask

    task automatic checkOutput();
        check("state", int'(state_out), m_state);
        check("dec_rst", int'(dec_rst_out), (m_state != M_RUN) ? 1 : 0);
        check("cmd_valid", int'(cmd_bus.cmd_valid_out), (m_q.size() != 0) ? 1 : 0);
        check("cmd_out", int'(cmd_bus.cmd_out), m_cmd_out);
        check("drop_count", int'(drop_count_out), m_drop);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge.
    task automatic applyStimulus(input logic en, input logic [31:0] code, input logic strobe,
                                 input logic [3:0] dstate, input logic ready);
        enable_in            = en;
        code_in              = code;
        new_code_in          = strobe;
        dec_state_in         = dstate;
        cmd_bus.cmd_ready_in = ready;
        @(posedge clk_in);
        modelStep();
        @(negedge clk_in);
        checkOutput();
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, ready);
    endtask

    task automatic sendFrame(input logic [31:0] code, input logic ready);
        applyStimulus(1'b1, code, 1'b1, 4'd0, ready);
    endtask

    task automatic drainFifo();
        drained.delete();
        for (int i = 0; i < 8; i++) begin
            if (cmd_bus.cmd_valid_out !== 1'b1) break;
            drained.push_back(int'(cmd_bus.cmd_out));
            applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, 1'b1);
        end
    endtask

    function automatic int drainedAt(input int idx);
        return (idx < drained.size()) ? drained[idx] : -1;
    endfunction

    task automatic checkResetValues(input string tag);
        check({tag, "_state"}, int'(state_out), 0);
        check({tag, "_dec_rst"}, int'(dec_rst_out), 1);
        check({tag, "_cmd_out"}, int'(cmd_bus.cmd_out), 0);
        check({tag, "_cmd_valid"}, int'(cmd_bus.cmd_valid_out), 0);
        check({tag, "_drop"}, int'(drop_count_out), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int zeros, ones, rc, dis_left, hang_left, sel;
        bit seen_start, left_start, reached;
        logic [7:0] c;
        logic [31:0] code;

        vecs[0]  = '{32'h00FF_18E7, 1'b1, 1'b0, 1'b1, 8'h18, 0};
        vecs[1]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 8'h18, 0};
        vecs[2]  = '{32'h00FF_18E6, 1'b1, 1'b0, 1'b1, 8'h18, 1};
        vecs[3]  = '{32'h01FE_18E7, 1'b1, 1'b0, 1'b1, 8'h18, 1};
        vecs[4]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h18, 1};
        vecs[5]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'h18, 1};
        vecs[6]  = '{32'h00FF_42BD, 1'b1, 1'b0, 1'b1, 8'h42, 1};
        vecs[7]  = '{32'h00FF_18E7, 1'b1, 1'b0, 1'b1, 8'h42, 1};
        vecs[8]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h18, 1};
        vecs[9]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h18, 1};
        vecs[10] = '{32'h00FF_00FF, 1'b1, 1'b0, 1'b1, 8'h00, 1};
        vecs[11] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[12] = '{32'h00FF_18E7, 1'b1, 1'b1, 1'b1, 8'h18, 1};
        vecs[13] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h18, 1};

        rst_n_in             = 1'b1;
        enable_in            = 1'b1;
        code_in              = '0;
        new_code_in          = 1'b0;
        dec_state_in         = '0;
        cmd_bus.cmd_ready_in = 1'b0;
        modelReset();
        #2 rst_n_in = 1'b0;
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
        checkResetValues("reset");

        // Startup: some OFF cycles for the reset synchronizer, four START cycles, then RUN.
        rst_n_in   = 1'b1;
        zeros      = 0;
        ones       = 0;
        seen_start = 1'b0;
        left_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
            if (!seen_start && state_out == 2'd0) zeros++;
            if (state_out == 2'd1) seen_start = 1'b1;
            if (seen_start && !left_start) begin
                if (state_out == 2'd1 && dec_rst_out == 1'b1) ones++;
                else left_start = 1'b1;
            end
        end
        check("startup_sync_delay", (zeros >= 1) ? 1 : 0, 1);
        check("startup_start_cycles", ones, RST_T);
        check("startup_run_state", int'(state_out), 2);
        check("startup_run_dec_rst", int'(dec_rst_out), 0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].code, vecs[i].strobe, 4'd0, vecs[i].ready);
            check($sformatf("vec%0d_valid", i), int'(cmd_bus.cmd_valid_out), int'(vecs[i].exp_valid));
            check($sformatf("vec%0d_cmd", i), int'(cmd_bus.cmd_out), int'(vecs[i].exp_cmd));
            check($sformatf("vec%0d_drop", i), int'(drop_count_out), vecs[i].exp_drop);
        end

        // Repeat suppression: second copy hidden, third copy after a full holdoff accepted.
        idle(HOLDOFF_T + 5, 1'b1);
        sendFrame(32'h00FF_5AA5, 1'b0);
        idle(10, 1'b0);
        sendFrame(32'h00FF_5AA5, 1'b0);
        idle(2, 1'b0);
        drainFifo();
        check("repeat_entries", drained.size(), 1);
        check("repeat_cmd", drainedAt(0), 'h5A);
        idle(HOLDOFF_T - 3, 1'b0);
        sendFrame(32'h00FF_5AA5, 1'b0);
        idle(1, 1'b0);
        drainFifo();
        check("repeat_after_holdoff_entries", drained.size(), 1);
        check("repeat_after_holdoff_cmd", drainedAt(0), 'h5A);

        // Overflow: fifth command dropped; then a push and pop together while full.
        sendFrame(32'h00FF_11EE, 1'b0);
        sendFrame(32'h00FF_22DD, 1'b0);
        sendFrame(32'h00FF_33CC, 1'b0);
        sendFrame(32'h00FF_44BB, 1'b0);
        sendFrame(32'h00FF_55AA, 1'b0);
        idle(1, 1'b0);
        check("overflow_drop", int'(drop_count_out), 2);
        check("overflow_head", int'(cmd_bus.cmd_out), 'h11);
        sendFrame(32'h00FF_6699, 1'b1);
        check("full_push_pop_drop", int'(drop_count_out), 2);
        drainFifo();
        check("full_push_pop_entries", drained.size(), 4);
        check("full_order0", drainedAt(0), 'h22);
        check("full_order1", drainedAt(1), 'h33);
        check("full_order2", drainedAt(2), 'h44);
        check("full_order3", drainedAt(3), 'h66);

        // Hung decoder: RECOVER exactly at TIMEOUT, four reset cycles, FIFO preserved.
        sendFrame(32'h00FF_7788, 1'b0);
        sendFrame(32'h00FF_12ED, 1'b0);
        for (int i = 1; i <= TIMEOUT_T; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0, 4'd3, 1'b0);
            if (i == TIMEOUT_T - 1) check("hang_not_yet", int'(state_out), 2);
        end
        check("hang_state", int'(state_out), 3);
        check("hang_dec_rst", int'(dec_rst_out), 1);
        rc = 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
            if (state_out == 2'd3) rc++;
            else break;
        end
        check("recover_cycles", rc, RST_T);
        check("recover_back_run", int'(state_out), 2);
        drainFifo();
        check("recover_entries", drained.size(), 2);
        check("recover_order0", drainedAt(0), 'h77);
        check("recover_order1", drainedAt(1), 'h12);

        // Disable mid-operation flushes the queue.
        sendFrame(32'h00FF_2AD5, 1'b0);
        check("pre_disable_valid", int'(cmd_bus.cmd_valid_out), 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
        check("disable_state", int'(state_out), 0);
        check("disable_valid", int'(cmd_bus.cmd_valid_out), 0);
        check("disable_dec_rst", int'(dec_rst_out), 1);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
            if (state_out == 2'd2) reached = 1'b1;
        end
        check("reenable_reaches_run", int'(reached), 1);
        check("reenable_fifo_empty", int'(cmd_bus.cmd_valid_out), 0);

        // Randomized traffic, hangs and enable dropouts against the model.
        dis_left  = 0;
        hang_left = 0;
        for (int i = 0; i < 6000; i++) begin
            logic en, strobe, ready;
            logic [3:0] dstate;
            if (dis_left > 0) dis_left--;
            else if ($urandom_range(0, 799) == 0) dis_left = $urandom_range(1, 5);
            en = (dis_left == 0);
            if (hang_left > 0) hang_left--;
            else if ($urandom_range(0, 399) == 0) hang_left = $urandom_range(150, 260);
            if (hang_left > 0) dstate = 4'($urandom_range(1, 15));
            else if ($urandom_range(0, 9) == 0) dstate = 4'($urandom_range(1, 15));
            else dstate = 4'd0;
            c   = 8'h10 + 8'($urandom_range(0, 3));
            sel = $urandom_range(0, 19);
            if (sel < 10) code = {DEV, ~DEV, c, ~c};
            else if (sel < 14) code = {DEV, ~DEV, c, ~c ^ 8'h01};
            else if (sel < 17) code = {DEV ^ 8'h01, ~(DEV ^ 8'h01), c, ~c};
            else code = $urandom;
            strobe = ($urandom_range(0, 5) == 0);
            ready  = ($urandom_range(0, 2) == 0);
            applyStimulus(en, code, strobe, dstate, ready);
        end

        // Drop counter saturation.
        idle(12, 1'b1);
        for (int i = 0; i < 300; i++) sendFrame(32'h00FF_18E6, 1'b1);
        check("drop_saturates", int'(drop_count_out), 255);

        // Asynchronous reset mid-cycle.
        #2 rst_n_in = 1'b0;
        modelReset();
        #1 checkResetValues("async_reset");
        @(negedge clk_in);
        applyStimulus(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
        rst_n_in = 1'b1;
        idle(10, 1'b0);
        check("post_reset_run", int'(state_out), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_command_ctrl.md
IR_COMMAND_CTRL -- requirements
Module: ir_command_ctrl

Interface
REQ-001 Parameter DEV_ADDR, 8'h00, device address accepted; frames for other addresses are ignored.
REQ-002 Parameter HOLDOFF, 11_000_000, repeat-suppression window in cycles (110 ms at 100 MHz).
REQ-003 Parameter TIMEOUT, 12_000_000, maximum consecutive cycles the decoder may remain non-IDLE.
REQ-004 Parameter RST_CYCLES, 4, length of a decoder reset pulse in cycles.
REQ-005 clk_in  input  1  system clock (100 MHz); the block uses one clock.
REQ-006 rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 enable_in  input  1  level; 1 = receiver active, 0 = decoder held in reset.
REQ-008 code_in  input  32  decoded frame from the decoder; bit 31 is the first received bit.
REQ-009 new_code_in  input  1  single-cycle strobe; code_in is valid this cycle.
REQ-010 dec_state_in  input  4  decoder state; 0 = IDLE.
REQ-011 dec_rst_out  output  1  active-high synchronous reset driven to the decoder.
REQ-012 cmd_out  output  8  command byte at the FIFO head.
REQ-013 cmd_valid_out  output  1  FIFO non-empty.
REQ-014 cmd_ready_in  input  1  consumer accepts cmd_out when cmd_valid_out is also 1.
REQ-015 drop_count_out  output  8  count of dropped frames, saturating at 255.
REQ-016 state_out  output  2  controller state: OFF=0, START=1, RUN=2, RECOVER=3.

Function
REQ-017 The state machine SHALL make these transitions:
- enable_in=0 in any state -> OFF; this has priority over all other transitions.
- OFF -> START when enable_in=1.
- START -> RUN after RST_CYCLES cycles.
- RUN -> RECOVER when dec_state_in!=0 for TIMEOUT consecutive cycles.
- RECOVER -> RUN after RST_CYCLES cycles.
REQ-018 dec_rst_out SHALL be 1 in OFF, START and RECOVER, and 0 in RUN.
REQ-019 The timeout counter SHALL clear whenever dec_state_in==0 or the state is not RUN.
REQ-020 Frame checks SHALL apply to fields A=code_in[31:24], nA=[23:16], C=[15:8], nC=[7:0].
REQ-021 new_code_in SHALL be evaluated only in RUN; in any other state it is ignored without effect.
REQ-022 An integrity failure (nA!=~A or nC!=~C) SHALL increment drop_count_out; nothing else changes.
REQ-023 A frame with valid integrity and A!=DEV_ADDR SHALL be ignored, with no count change.
REQ-024 A valid frame SHALL reload the holdoff counter to HOLDOFF; this includes frames that are then suppressed.
REQ-025 The holdoff counter SHALL decrement by 1 per cycle down to 0.
REQ-026 A valid frame SHALL be suppressed (not pushed, not counted) when C equals the last accepted command and the holdoff counter is nonzero.
REQ-027 Otherwise C SHALL be pushed into the FIFO and recorded as the last accepted command.
REQ-028 The FIFO SHALL hold 4 entries, first-in first-out.
REQ-029 A push SHALL occur on the edge ending the strobe cycle, so cmd_valid_out rises 1 cycle after new_code_in when the FIFO was empty.
REQ-030 A pop SHALL occur on any cycle where cmd_valid_out && cmd_ready_in.
REQ-031 When a push is attempted with the FIFO full and no simultaneous pop, the command SHALL be discarded and drop_count_out incremented.
REQ-032 When the FIFO is full and a push and a pop occur in the same cycle, both SHALL succeed.
REQ-033 When the FIFO is empty, cmd_valid_out SHALL be 0 and cmd_out SHALL hold its last value.
REQ-034 A transition to OFF SHALL flush the FIFO, clear the holdoff counter and clear the last accepted command.
REQ-035 A transition to RECOVER SHALL preserve FIFO contents.
REQ-036 drop_count_out SHALL clear only on reset; it SHALL saturate at 255 and not wrap.

Reset
REQ-037 While rst_n_in=0, every register SHALL be forced to its reset value immediately.
REQ-038 Reset values SHALL be:
- state OFF;
- dec_rst_out=1;
- cmd_out=0, cmd_valid_out=0, drop_count_out=0;
- FIFO empty, all counters 0.
REQ-039 Reset deassertion SHALL be synchronized to clk_in; the first state change occurs no earlier than the second edge after release.

Verification
REQ-040 Startup: enable_in=1 after reset -> state_out 0->1, dec_rst_out=1 for exactly 4 cycles, then state_out=2 and dec_rst_out=0.
REQ-041 Accept: code 32'h00FF_18E7 strobed in RUN -> next cycle cmd_valid_out=1, cmd_out=8'h18; drop_count_out unchanged.
REQ-042 Filter and integrity: 32'h00FF_18E6 -> drop_count_out=1, no push; 32'h01FE_18E7 -> ignored, count stays 1.
REQ-043 Repeat: 32'h00FF_18E7 twice within 1000 cycles -> one FIFO entry; a third copy after HOLDOFF idle cycles -> second entry.
REQ-044 Overflow: cmd_ready_in=0, 5 distinct valid commands -> 4 entries, drop_count_out=1; a full FIFO with a same-cycle push and pop keeps 4 entries in correct order.
REQ-045 Hang and disable:
- dec_state_in=3 held for TIMEOUT cycles -> state_out=3, dec_rst_out pulses for 4 cycles, FIFO contents preserved.
- enable_in=0 mid-operation -> state_out=0, cmd_valid_out=0.
